// File: rtl/sel_scanner.sv
// Sequential channel-select generator feeding a one-hot decoder: walks enabled
// channels 0..last_idx, holds each for a programmable dwell and strobes sample.
module sel_scanner #(
    parameter  int WIDTH   = 5,
    parameter  int DWELL_W = 4,
    localparam int OUTS    = 1 << WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [WIDTH-1:0]   last_idx_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic [OUTS-1:0]    mask_i,
    output logic [WIDTH-1:0]   sel_o,
    output logic               sel_valid_o,
    output logic               sample_o,
    output logic               busy_o,
    output logic               done_o
);

    // state   | meaning
    // S_IDLE  | waiting for start, sel holds last index
    // S_SEEK  | testing one candidate channel per cycle
    // S_DWELL | holding an enabled channel, cnt counts down to the sample cycle
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEEK  = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   last_q, last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [OUTS-1:0]    mask_q, mask_d;

    logic at_last;
    logic cnt_zero;

    assign at_last  = (idx_q == last_q);
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    last_d  = last_idx_i;
                    dwell_d = dwell_i;
                    mask_d  = mask_i;
                    idx_d   = '0;
                    state_d = S_SEEK;
                end
            end
            S_SEEK: begin
                if (mask_q[idx_q]) begin
                    cnt_d   = dwell_q;
                    state_d = S_DWELL;
                end else if (at_last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + WIDTH'(1);
                end
            end
            S_DWELL: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (at_last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + WIDTH'(1);
                    state_d = S_SEEK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition above, including a pending start.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    assign sel_o       = idx_q;
    assign sel_valid_o = (state_q == S_DWELL);
    assign sample_o    = (state_q == S_DWELL) && cnt_zero;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_sel_scanner.sv
// Scoreboard bench for sel_scanner: expected sample/done events are queued with
// their select value and cycle offset from the accepting start edge.
module tb_sel_scanner;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [4:0]  last_idx_i;
    logic [3:0]  dwell_i;
    logic [31:0] mask_i;
    logic [4:0]  sel_o;
    logic        sel_valid_o;
    logic        sample_o;
    logic        busy_o;
    logic        done_o;

    sel_scanner #(.WIDTH(5), .DWELL_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .last_idx_i  (last_idx_i),
        .dwell_i     (dwell_i),
        .mask_i      (mask_i),
        .sel_o       (sel_o),
        .sel_valid_o (sel_valid_o),
        .sample_o    (sample_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = sample, 1 = done
        int sel;
        int rel;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  t0 = 0;
    int  valid_cnt = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc - t0);
        end
    endtask

    function automatic void push(input int kind, input int sel, input int rel);
        ev_t e;
        e.kind = kind;
        e.sel  = sel;
        e.rel  = rel;
        exp_q.push_back(e);
    endfunction

    // Monitor: pops one expected event per sample/done strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sel_valid_o) valid_cnt++;
            if (sample_o || done_o) begin
                checks++;
                if (sample_o && done_o) begin
                    errors++;
                    $display("FAIL overlap: sample and done together at cycle %0d", cyc - t0);
                end else if (sample_o && !sel_valid_o) begin
                    errors++;
                    $display("FAIL sample_no_valid: sample without sel_valid at cycle %0d", cyc - t0);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: kind %0d sel %0d at cycle %0d, none expected",
                             done_o ? 1 : 0, sel_o, cyc - t0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if ((done_o ? 1 : 0) != e.kind || int'(sel_o) != e.sel || (cyc - t0) != e.rel) begin
                        errors++;
                        $display("FAIL event: got kind %0d sel %0d cycle %0d expected kind %0d sel %0d cycle %0d",
                                 done_o ? 1 : 0, sel_o, cyc - t0, e.kind, e.sel, e.rel);
                    end
                end
            end
        end
    end

    task automatic run_scan(input string name, input logic [4:0] li, input logic [3:0] dw,
                            input logic [31:0] mk, input int exp_busy, input int exp_valid,
                            input int poke);
        int n;
        @(negedge clk);
        last_idx_i = li;
        dwell_i    = dw;
        mask_i     = mk;
        start_i    = 1'b1;
        valid_cnt  = 0;
        t0         = cyc;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (busy_o && n < 300) begin
            n++;
            if (n == poke) begin
                mask_i     = '1;
                last_idx_i = 5'd31;
                dwell_i    = 4'd15;
                start_i    = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        check({name, "_busy_cycles"}, n, exp_busy);
        check({name, "_valid_cycles"}, valid_cnt, exp_valid);
        check({name, "_missing_events"}, exp_q.size(), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        last_idx_i = '0;
        dwell_i    = '0;
        mask_i     = '0;
        repeat (2) @(negedge clk);
        check("reset_sel", sel_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_outs", {sel_valid_o, sample_o, done_o}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // all channels, last 2, dwell 1
        push(0, 0, 3); push(0, 1, 6); push(0, 2, 9); push(1, 2, 10);
        run_scan("all3", 5'd2, 4'd1, 32'hFFFF_FFFF, 10, 6, 0);
        check("idle_keeps_sel", sel_o, 2);

        // sparse mask, dwell 0
        push(0, 1, 3); push(0, 3, 6); push(1, 3, 7);
        run_scan("sparse", 5'd3, 4'd0, 32'b1010, 7, 2, 0);

        // empty mask over full range
        push(1, 31, 33);
        run_scan("empty", 5'd31, 4'd0, 32'h0, 33, 0, 0);

        // only the top channel enabled
        push(0, 31, 33); push(1, 31, 34);
        run_scan("top", 5'd31, 4'd0, 32'h8000_0000, 34, 1, 0);

        // abort in second dwell cycle of channel 0 with start also high
        @(negedge clk);
        last_idx_i = 5'd1;
        dwell_i    = 4'd2;
        mask_i     = 32'b11;
        start_i    = 1'b1;
        valid_cnt  = 0;
        t0         = cyc;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_valid", sel_valid_o, 1);
        check("abort_pre_sel", sel_o, 0);
        abort_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_sel", sel_o, 0);
        check("abort_valid", sel_valid_o, 0);
        repeat (3) @(negedge clk);
        check("abort_no_start", busy_o, 0);

        push(0, 0, 4); push(0, 1, 8); push(1, 1, 9);
        run_scan("post_abort", 5'd1, 4'd2, 32'b11, 9, 6, 0);

        // start and config changes mid-scan are ignored
        push(0, 0, 3); push(0, 2, 7); push(1, 2, 8);
        run_scan("midchg", 5'd2, 4'd1, 32'b101, 8, 4, 4);

        // asynchronous reset in the middle of a dwell
        @(negedge clk);
        last_idx_i = 5'd2;
        dwell_i    = 4'd3;
        mask_i     = 32'b111;
        start_i    = 1'b1;
        t0         = cyc;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("rst_pre_valid", sel_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_sel", sel_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_outs", {sel_valid_o, sample_o, done_o}, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        push(0, 0, 2); push(1, 0, 3);
        run_scan("after_rst", 5'd0, 4'd0, 32'b1, 3, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
